// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory stage: access size
// encodings, the data-memory controller state type and an alignment helper.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

    // A size code of 2'b11 is handled exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting for a little-endian 32-bit bus.
// Store side: byte-enable generation and lane replication of write data.
// Load side: lane extraction and sign/zero extension of a read word.
// Purely combinational so it can be shared with other refill/fetch paths.
module mem_lane_fmt
    import mips_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_signed,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store formatting: enables follow the address, data is replicated on every lane.
    always_comb begin
        st_be    = 4'hF;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = 4'b0011 << st_addr_lo;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'hF;
                st_wdata = st_data;
            end
        endcase
    end

    // Load formatting: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        ld_byte_s = ld_word[7:0];
        case (ld_addr_lo)
            2'b00:   ld_byte_s = ld_word[7:0];
            2'b01:   ld_byte_s = ld_word[15:8];
            2'b10:   ld_byte_s = ld_word[23:16];
            2'b11:   ld_byte_s = ld_word[31:24];
            default: ld_byte_s = ld_word[7:0];
        endcase

        if (ld_addr_lo[1]) begin
            ld_half_s = ld_word[31:16];
        end else begin
            ld_half_s = ld_word[15:0];
        end

        ld_data = ld_word;
        case (ld_size)
            SZ_BYTE: begin
                if (ld_signed) begin
                    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
                end else begin
                    ld_data = {24'h000000, ld_byte_s};
                end
            end
            SZ_HALF: begin
                if (ld_signed) begin
                    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
                end else begin
                    ld_data = {16'h0000, ld_half_s};
                end
            end
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage data-memory controller. Turns M-stage loads/stores into a
// single aligned word transaction on a req/ack bus, stalls the pipeline until
// the bus answers or a timeout expires, and formats load data.
module dmem_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [1:0]  memsizeM,
    input  logic        memsignedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        buserrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    dmem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [1:0]    lo_q, lo_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;

    logic          access_s;
    logic          misaligned_s;
    logic          stall_s;
    logic          adel_s;
    logic          ades_s;
    logic [CW-1:0] cnt_inc_s;
    logic [3:0]    st_be_s;
    logic [31:0]   st_wdata_s;
    logic [31:0]   ld_data_s;

    // Store formatting works on the live M-stage inputs; load formatting on
    // the address/size captured when the transaction was launched.
    mem_lane_fmt u_fmt (
        .st_size    (memsizeM),
        .st_addr_lo (aluoutM[1:0]),
        .st_data    (writedataM),
        .st_be      (st_be_s),
        .st_wdata   (st_wdata_s),
        .ld_size    (size_q),
        .ld_addr_lo (lo_q),
        .ld_signed  (signed_q),
        .ld_word    (bus_rdata),
        .ld_data    (ld_data_s)
    );

    assign access_s     = memreadM | memwriteM;
    assign misaligned_s = is_misaligned(memsizeM, aluoutM[1:0]);
    assign cnt_inc_s    = cnt_q + {{(CW-1){1'b0}}, 1'b1};

    // Next-state, transaction launch/complete and combinational M-stage flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        readdata_d  = readdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        lo_d        = lo_q;
        size_d      = size_q;
        signed_d    = signed_q;
        stall_s     = 1'b0;
        adel_s      = 1'b0;
        ades_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_s && misaligned_s) begin
                    adel_s = ~memwriteM;
                    ades_s = memwriteM;
                end else if (access_s) begin
                    stall_s     = 1'b1;
                    state_d     = BUSY;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = memwriteM;
                    bus_addr_d  = {aluoutM[31:2], 2'b00};
                    lo_d        = aluoutM[1:0];
                    size_d      = memsizeM;
                    signed_d    = memsignedM;
                    if (memwriteM) begin
                        bus_be_d    = st_be_s;
                        bus_wdata_d = st_wdata_s;
                    end else begin
                        bus_be_d    = 4'hF;
                        bus_wdata_d = 32'h0000_0000;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        readdata_d = ld_data_s;
                    end else begin
                        readdata_d = readdata_q;
                    end
                end else if (cnt_inc_s == TO_LIMIT) begin
                    state_d    = DONE;
                    bus_req_d  = 1'b0;
                    err_d      = 1'b1;
                    readdata_d = 32'h0000_0000;
                    cnt_d      = cnt_inc_s;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                err_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            readdata_q  <= 32'h0000_0000;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0000_0000;
            lo_q        <= 2'b00;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            readdata_q  <= readdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
        end
    end

    // Pipeline-facing flags are forced low while reset is held.
    assign stallM    = stall_s & ~rst;
    assign adelM     = adel_s & ~rst;
    assign adesM     = ades_s & ~rst;
    assign buserrM   = (state_q == DONE) & err_q & ~rst;
    assign readdataM = readdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases from the test plan plus
// randomized loads/stores against a behavioural byte-lane model.
module tb_dmem_ctrl;
    import mips_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreadM, memwriteM, memsignedM;
    logic [1:0]  memsizeM;
    logic [31:0] aluoutM, writedataM, readdataM;
    logic        stallM, adelM, adesM, buserrM;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd = 32'h0;

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .memsizeM   (memsizeM),
        .memsignedM (memsignedM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .adelM      (adelM),
        .adesM      (adesM),
        .buserrM    (buserrM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_misal(input logic [1:0] sz, input logic [31:0] addr);
        return (int'(addr[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr, input bit wr);
        int m;
        if (!wr) return 4'hF;
        m = ((1 << nbytes(sz)) - 1) << int'(addr[1:0]);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] lo8, lo16;
        lo8  = wd & 32'h0000_00FF;
        lo16 = wd & 32'h0000_FFFF;
        if (nbytes(sz) == 1) return lo8 * 32'h0101_0101;
        if (nbytes(sz) == 2) return lo16 * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sgn,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v, mask;
        int n;
        n = nbytes(sz);
        v = rdata >> (8 * int'(addr[1:0]));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v = v & mask;
        if (sgn && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One M-stage access; delay = idle bus cycles before ack, negative = never.
    task automatic run_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input int delay);
        bit timeout;
        int exp_stall, stall_cnt, k;
        @(posedge clk); #1;
        memreadM = rd; memwriteM = wr; memsizeM = sz; memsignedM = sgn;
        aluoutM = addr; writedataM = wd; bus_ack = 1'b0; bus_rdata = $urandom;
        @(negedge clk);
        if (model_misal(sz, addr)) begin
            check_val("adel", 32'(adelM), 32'(!wr));
            check_val("ades", 32'(adesM), 32'(wr));
            check_val("stall_mis", 32'(stallM), 32'd0);
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check_val("req_mis", 32'(bus_req), 32'd0);
            end
            check_val("rd_hold_mis", readdataM, exp_rd);
            @(posedge clk); #1;
            memreadM = 1'b0; memwriteM = 1'b0;
        end else begin
            check_val("adel0", 32'(adelM), 32'd0);
            check_val("ades0", 32'(adesM), 32'd0);
            timeout   = (delay < 0) || (delay + 1 > TO);
            exp_stall = timeout ? TO + 1 : delay + 2;
            stall_cnt = 0;
            k = 0;
            while (stallM === 1'b1 && stall_cnt < 64) begin
                stall_cnt++;
                @(posedge clk); #1;
                k++;
                bus_ack   = (delay >= 0) && (k == delay + 1);
                bus_rdata = bus_ack ? rdata : $urandom;
                if (k == 1) begin
                    check_val("req", 32'(bus_req), 32'd1);
                    check_val("we", 32'(bus_we), 32'(wr));
                    check_val("addr", bus_addr, {addr[31:2], 2'b00});
                    check_val("be", 32'(bus_be), 32'(model_be(sz, addr, wr)));
                    if (wr) check_val("wdata", bus_wdata, model_wdata(sz, wd));
                end
                @(negedge clk);
            end
            check_val("stall_cycles", stall_cnt, exp_stall);
            check_val("buserr", 32'(buserrM), 32'(timeout));
            check_val("req_done", 32'(bus_req), 32'd0);
            if (timeout) exp_rd = 32'h0;
            else if (!wr) exp_rd = model_load(sz, sgn, addr, rdata);
            check_val("readdata", readdataM, exp_rd);
            // ack in DONE must be ignored
            bus_ack = 1'b1; bus_rdata = $urandom;
            @(posedge clk); #1;
            memreadM = 1'b0; memwriteM = 1'b0; bus_ack = 1'b0;
            @(negedge clk);
            check_val("rd_hold", readdataM, exp_rd);
            check_val("req_idle", 32'(bus_req), 32'd0);
            check_val("buserr_idle", 32'(buserrM), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; memreadM = 1'b1; memwriteM = 1'b0; memsizeM = SZ_WORD; memsignedM = 1'b0;
        aluoutM = 32'h101; writedataM = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_stall", 32'(stallM), 32'd0);
        check_val("rst_adel", 32'(adelM), 32'd0);
        check_val("rst_req", 32'(bus_req), 32'd0);
        check_val("rst_rd", readdataM, 32'h0);
        check_val("rst_be", 32'(bus_be), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; memreadM = 1'b0;

        // directed cases
        run_access(1, 0, SZ_WORD, 0, 32'h104, 32'h0, 32'hDEADBEEF, 0);
        check_val("word_load", readdataM, 32'hDEADBEEF);
        run_access(1, 0, SZ_BYTE, 1, 32'h203, 32'h0, 32'h80112233, 1);
        check_val("sbyte_load", readdataM, 32'hFFFFFF80);
        run_access(1, 0, SZ_BYTE, 0, 32'h203, 32'h0, 32'h80112233, 0);
        check_val("ubyte_load", readdataM, 32'h00000080);
        run_access(0, 1, SZ_HALF, 0, 32'h302, 32'h0000ABCD, 32'h0, 2);
        run_access(1, 0, SZ_WORD, 0, 32'h101, 32'h0, 32'h0, 0);
        run_access(0, 1, SZ_WORD, 0, 32'h101, 32'h1234, 32'h0, 0);
        run_access(1, 0, SZ_HALF, 1, 32'h206, 32'h0, 32'h9ABC1234, -1);
        check_val("timeout_rd", readdataM, 32'h0);
        run_access(1, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 32'h0, TO - 1);

        // reset during second BUSY cycle
        @(posedge clk); #1;
        memreadM = 1'b1; memwriteM = 1'b0; memsizeM = SZ_WORD; aluoutM = 32'h400; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort_req1", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_stall", 32'(stallM), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; memreadM = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
        exp_rd = 32'h0;
        @(negedge clk);
        check_val("abort_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check_val("abort_rd", readdataM, exp_rd);
        check_val("abort_stall2", 32'(stallM), 32'd0);

        // back-to-back loads
        run_access(1, 0, SZ_WORD, 0, 32'h500, 32'h0, 32'h11111111, 0);
        run_access(1, 0, SZ_HALF, 0, 32'h502, 32'h0, 32'h8765ABCD, 0);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            bit rd, wr, sgn;
            logic [1:0] sz;
            logic [31:0] addr;
            int dly;
            wr   = $urandom_range(0, 1) == 1;
            rd   = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
            sgn  = $urandom_range(0, 1) == 1;
            sz   = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'(int'(addr[1:0]) & ~(nbytes(sz) - 1));
            dly  = int'($urandom_range(0, 6)) - 1;
            run_access(rd, wr, sz, sgn, addr, $urandom, $urandom, dly);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
